// File: rtl/branch_predict_bht_pkg.sv
// Shared types and constants for the branch history table predictor.
package branch_predict_bht_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Not-taken fall-through skips the branch delay slot.
  localparam logic [31:0] DELAY_SLOT_OFS = 32'd8;

endpackage

// File: rtl/branch_predict_bht_sat_ctr.sv
// 2-bit saturating counter next-state: increments on inc=1, decrements otherwise.
module bht_sat_ctr
  import branch_predict_bht_pkg::*;
(
  input  ctr_e cur,
  input  logic inc,
  output ctr_e nxt
);

  always_comb begin
    nxt = cur;
    case (cur)
      CTR_SNT: nxt = inc ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = inc ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = inc ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = inc ? CTR_ST  : CTR_WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predict_bht.sv
// Direct-mapped tagged BHT: IF-stage lookup, IF->ID capture of the prediction,
// ID-stage resolve (mispredict/redirect) and table training.
module branch_predict_bht
  import branch_predict_bht_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        if_id_en,
  input  logic        id_flush,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  ctr_e              ctr_q    [ENTRIES];
  ctr_e              ctr_d    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [31:0]       target_d [ENTRIES];

  logic        cap_valid_q, cap_valid_d;
  logic        cap_taken_q, cap_taken_d;
  logic [31:0] cap_target_q, cap_target_d;

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit, pred_res;
  ctr_e             ctr_upd;
  logic             unused_if_pc_lsb;

  assign if_idx           = if_pc[IDX_W+1:2];
  assign if_tag           = if_pc[31:IDX_W+2];
  assign upd_idx          = upd_pc[IDX_W+1:2];
  assign upd_tag          = upd_pc[31:IDX_W+2];
  assign unused_if_pc_lsb = ^if_pc[1:0];

  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit & ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : '0;
  end

  always_comb begin
    cap_valid_d  = cap_valid_q;
    cap_taken_d  = cap_taken_q;
    cap_target_d = cap_target_q;
    if (id_flush) begin
      cap_valid_d  = 1'b0;
      cap_taken_d  = 1'b0;
      cap_target_d = '0;
    end else if (if_id_en) begin
      cap_valid_d  = 1'b1;
      cap_taken_d  = pred_taken;
      cap_target_d = pred_target;
    end
  end

  always_comb begin
    pred_res    = cap_valid_q & cap_taken_q;
    mispredict  = upd_valid &
                  ((pred_res != upd_taken) | (upd_taken & (cap_target_q != upd_target)));
    redirect_pc = '0;
    if (mispredict) redirect_pc = upd_taken ? upd_target : (upd_pc + DELAY_SLOT_OFS);
  end

  bht_sat_ctr u_sat_ctr (
    .cur (ctr_q[upd_idx]),
    .inc (upd_taken),
    .nxt (ctr_upd)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    if (upd_valid) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = ctr_upd;
        if (upd_taken) target_d[upd_idx] = upd_target;
      end else begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        ctr_d[upd_idx]    = upd_taken ? CTR_WT : CTR_WNT;
        target_d[upd_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
      cap_valid_q  <= 1'b0;
      cap_taken_q  <= 1'b0;
      cap_target_q <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      ctr_q        <= ctr_d;
      target_q     <= target_d;
      cap_valid_q  <= cap_valid_d;
      cap_taken_q  <= cap_taken_d;
      cap_target_q <= cap_target_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_bht.sv
// Scoreboard bench for branch_predict_bht: directed per-cycle vectors push expected
// responses; a negedge monitor pops and compares lookup and resolve outputs.
module tb_branch_predict_bht;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        if_id_en = 1'b0;
  logic        id_flush = 1'b0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        lk_chk = 1'b0;

  always #5 clk = ~clk;

  branch_predict_bht #(.IDX_W(6), .TAG_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_pc       (if_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .if_id_en    (if_id_en),
    .id_flush    (id_flush),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    bit rst, lk, en, fl;
    logic [31:0] pc;
    bit ept;
    logic [31:0] eptg;
    bit uv, ut;
    logic [31:0] upc, utg;
    bit emp;
    logic [31:0] erd;
  } vec_t;

  typedef struct {
    string name;
    bit a;
    logic [31:0] b;
  } exp_t;

  vec_t vecs[$];
  exp_t lk_q[$];
  exp_t up_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  function automatic vec_t blank();
    vec_t v;
    v = '{rst: 0, lk: 0, en: 0, fl: 0, pc: '0, ept: 0, eptg: '0,
          uv: 0, ut: 0, upc: '0, utg: '0, emp: 0, erd: '0};
    return v;
  endfunction

  function automatic void lk(bit rst, bit en, bit fl, logic [31:0] pc, bit ept, logic [31:0] eptg);
    vec_t v = blank();
    v.rst = rst; v.lk = 1; v.en = en; v.fl = fl; v.pc = pc; v.ept = ept; v.eptg = eptg;
    vecs.push_back(v);
  endfunction

  function automatic void up(logic [31:0] upc, bit ut, logic [31:0] utg, bit emp, logic [31:0] erd);
    vec_t v = blank();
    v.uv = 1; v.upc = upc; v.ut = ut; v.utg = utg; v.emp = emp; v.erd = erd;
    vecs.push_back(v);
  endfunction

  function automatic void lkup(logic [31:0] pc, bit ept, logic [31:0] eptg,
                               logic [31:0] upc, bit ut, logic [31:0] utg, bit emp, logic [31:0] erd);
    vec_t v = blank();
    v.lk = 1; v.pc = pc; v.ept = ept; v.eptg = eptg;
    v.uv = 1; v.upc = upc; v.ut = ut; v.utg = utg; v.emp = emp; v.erd = erd;
    vecs.push_back(v);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (lk_chk) begin
      if (lk_q.size() == 0) chk("lookup_queue_nonempty", 32'd0, 32'd1);
      else begin
        e = lk_q.pop_front();
        chk({e.name, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e.a});
        chk({e.name, ".pred_target"}, pred_target, e.b);
      end
    end
    if (upd_valid) begin
      if (up_q.size() == 0) chk("resolve_queue_nonempty", 32'd0, 32'd1);
      else begin
        e = up_q.pop_front();
        chk({e.name, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.a});
        chk({e.name, ".redirect_pc"}, redirect_pc, e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // reset state
    lk(1, 0, 0, 32'h0000_1234, 0, 32'h0);
    lk(0, 0, 0, 32'h0000_3000, 0, 32'h0);
    // cold branch; same-cycle lookup sees pre-update contents
    lkup(32'h3000, 0, 32'h0, 32'h3000, 1, 32'h3040, 1, 32'h3040);
    lk(0, 0, 0, 32'h3000, 1, 32'h3040);
    // saturate up
    up(32'h3000, 1, 32'h3040, 1, 32'h3040);
    up(32'h3000, 1, 32'h3040, 1, 32'h3040);
    up(32'h3000, 1, 32'h3040, 1, 32'h3040);
    // capture taken, then not-taken mispredict
    lk(0, 1, 0, 32'h3000, 1, 32'h3040);
    up(32'h3000, 0, 32'h0, 1, 32'h3008);
    lk(0, 0, 0, 32'h3000, 1, 32'h3040);
    up(32'h3000, 0, 32'h0, 1, 32'h3008);
    up(32'h3000, 0, 32'h0, 1, 32'h3008);
    lk(0, 0, 0, 32'h3000, 0, 32'h0);
    // correctly predicted not-taken at counter floor
    lk(0, 1, 0, 32'h3000, 0, 32'h0);
    up(32'h3000, 0, 32'h0, 0, 32'h0);
    up(32'h3000, 1, 32'h3040, 1, 32'h3040);
    up(32'h3000, 1, 32'h3040, 1, 32'h3040);
    lk(0, 0, 0, 32'h3000, 1, 32'h3040);
    // alias at same index, different tag
    lk(0, 0, 0, 32'h3100, 0, 32'h0);
    up(32'h3100, 1, 32'h3200, 1, 32'h3200);
    lk(0, 0, 0, 32'h3100, 1, 32'h3200);
    lk(0, 0, 0, 32'h3000, 0, 32'h0);
    up(32'h3100, 0, 32'h0, 0, 32'h0);
    lk(0, 0, 0, 32'h3100, 0, 32'h0);
    // stall holds capture, then flush clears it
    up(32'h3100, 1, 32'h3200, 1, 32'h3200);
    lk(0, 1, 0, 32'h3100, 1, 32'h3200);
    lk(0, 0, 0, 32'h3000, 0, 32'h0);
    lk(0, 0, 0, 32'h3000, 0, 32'h0);
    lk(0, 0, 0, 32'h3000, 0, 32'h0);
    up(32'h3100, 1, 32'h3200, 0, 32'h0);
    up(32'h3100, 1, 32'h3280, 1, 32'h3280);
    up(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0000_0004);
    lk(0, 1, 1, 32'h3100, 1, 32'h3280);
    up(32'h3100, 1, 32'h3280, 1, 32'h3280);
    // reset mid-operation, then normal training
    lk(1, 0, 0, 32'h3100, 0, 32'h0);
    lk(0, 0, 0, 32'h3100, 0, 32'h0);
    up(32'h3000, 1, 32'h3040, 1, 32'h3040);
    lk(0, 0, 0, 32'h3000, 1, 32'h3040);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      reset      = !v.rst;
      if_pc      = v.pc;
      if_id_en   = v.en;
      id_flush   = v.fl;
      upd_valid  = v.uv;
      upd_pc     = v.upc;
      upd_taken  = v.ut;
      upd_target = v.utg;
      lk_chk     = v.lk;
      if (v.lk) lk_q.push_back('{$sformatf("v%0d", i), v.ept, v.eptg});
      if (v.uv) up_q.push_back('{$sformatf("v%0d", i), v.emp, v.erd});
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    if_id_en  = 1'b0;
    id_flush  = 1'b0;
    upd_valid = 1'b0;
    lk_chk    = 1'b0;
    repeat (3) @(posedge clk);
    chk("lookup_queue_drained", lk_q.size(), 32'd0);
    chk("resolve_queue_drained", up_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
